// File: rtl/mem_rd_issue_queue.sv
// Read-request issue queue: FIFO-buffered client reads, tag-tracked outstanding table, return matching.
// Optional per-entry age timeout is enabled by defining MEM_RD_TIMEOUT_EN.
module mem_rd_issue_queue #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 8,
    parameter int MAX_OUT        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_address,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_address,
    input  logic                         rd_ret_ack,
    input  logic [ADDR_W-1:0]            rd_ret_address,
    input  logic [DATA_W-1:0]            rd_ret_data,
    output logic                         resp_valid,
    output logic [ADDR_W-1:0]            resp_address,
    output logic [DATA_W-1:0]            resp_data,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         err_unexpected,
    output logic                         err_timeout
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OUT_W  = $clog2(MAX_OUT) + 1;
    localparam int SLOT_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [ADDR_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic              fifo_empty, fifo_full;
    logic              push, issue;
    logic [ADDR_W-1:0] head;

    logic [MAX_OUT-1:0] tvalid_q, tvalid_d;
    logic [ADDR_W-1:0]  ttag_q [MAX_OUT];
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;

    logic              head_hit, ret_hit, free_found, ret_free;
    logic [SLOT_W-1:0] ret_idx, free_idx;

    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_address_q, rd_address_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_address_q, resp_address_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              err_unexp_q, err_unexp_d;

    assign fifo_empty = (fcnt_q == '0);
    assign fifo_full  = (fcnt_q == CNT_W'(DEPTH));
    assign head       = fifo_q[rd_ptr_q];
    assign push       = req_valid && !fifo_full;

    // CAM search over registered table state: head duplicate, return match, lowest free slot
    always_comb begin
        head_hit   = 1'b0;
        ret_hit    = 1'b0;
        ret_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if (tvalid_q[i] && (ttag_q[i] == head)) begin
                head_hit = 1'b1;
            end
            if (tvalid_q[i] && (ttag_q[i] == rd_ret_address) && !ret_hit) begin
                ret_hit = 1'b1;
                ret_idx = SLOT_W'(i);
            end
            if (!tvalid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    assign issue    = !fifo_empty && (outstanding_q < OUT_W'(MAX_OUT)) && !head_hit && free_found;
    assign ret_free = rd_ret_ack && ret_hit;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !issue) begin
            fcnt_d = fcnt_q + CNT_W'(1);
        end else if (!push && issue) begin
            fcnt_d = fcnt_q - CNT_W'(1);
        end
    end

    // A slot freed and a slot allocated on the same edge are always distinct slots
    always_comb begin
        tvalid_d      = tvalid_q;
        outstanding_d = outstanding_q;
        if (ret_free) begin
            tvalid_d[ret_idx] = 1'b0;
        end
        if (issue) begin
            tvalid_d[free_idx] = 1'b1;
        end
        if (issue && !ret_free) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!issue && ret_free) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_comb begin
        rd_en_d        = issue;
        rd_address_d   = issue ? head : rd_address_q;
        resp_valid_d   = ret_free;
        resp_address_d = ret_free ? rd_ret_address : resp_address_q;
        resp_data_d    = ret_free ? rd_ret_data : resp_data_q;
        err_unexp_d    = err_unexp_q || (rd_ret_ack && !ret_hit);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_address;
        end
        if (issue) begin
            ttag_q[free_idx] <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fcnt_q         <= '0;
            tvalid_q       <= '0;
            outstanding_q  <= '0;
            rd_en_q        <= 1'b0;
            rd_address_q   <= '0;
            resp_valid_q   <= 1'b0;
            resp_address_q <= '0;
            resp_data_q    <= '0;
            err_unexp_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fcnt_q         <= fcnt_d;
            tvalid_q       <= tvalid_d;
            outstanding_q  <= outstanding_d;
            rd_en_q        <= rd_en_d;
            rd_address_q   <= rd_address_d;
            resp_valid_q   <= resp_valid_d;
            resp_address_q <= resp_address_d;
            resp_data_q    <= resp_data_d;
            err_unexp_q    <= err_unexp_d;
        end
    end

`ifdef MEM_RD_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [AGE_W-1:0] age_q [MAX_OUT];
    logic             err_to_q, err_to_d;

    always_comb begin
        err_to_d = err_to_q;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            if (tvalid_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYCLES))) begin
                err_to_d = 1'b1;
            end
        end
    end

    // Age saturates at the limit so a long-lived entry never wraps back below it
    always_ff @(posedge clk) begin
        if (reset) begin
            err_to_q <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            err_to_q <= err_to_d;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                if (issue && (free_idx == SLOT_W'(i))) begin
                    age_q[i] <= '0;
                end else if (tvalid_q[i] && (age_q[i] < AGE_W'(TIMEOUT_CYCLES))) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign req_ready      = !fifo_full;
    assign rd_en          = rd_en_q;
    assign rd_address     = rd_address_q;
    assign resp_valid     = resp_valid_q;
    assign resp_address   = resp_address_q;
    assign resp_data      = resp_data_q;
    assign outstanding    = outstanding_q;
    assign err_unexpected = err_unexp_q;

endmodule

// File: tb/tb_mem_rd_issue_queue.sv
// Directed bench for mem_rd_issue_queue: a vector table for basic issue/return/duplicate flow,
// plus hand-written sequences for table-full stall, FIFO-full, timeout and mid-flight reset.
module tb_mem_rd_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_address;
    logic        rd_en;
    logic [15:0] rd_address;
    logic        rd_ret_ack;
    logic [15:0] rd_ret_address;
    logic [15:0] rd_ret_data;
    logic        resp_valid;
    logic [15:0] resp_address;
    logic [15:0] resp_data;
    logic [2:0]  outstanding;
    logic        err_unexpected;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_rd_issue_queue #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(8), .MAX_OUT(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .rd_en(rd_en), .rd_address(rd_address),
        .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data),
        .resp_valid(resp_valid), .resp_address(resp_address), .resp_data(resp_data),
        .outstanding(outstanding), .err_unexpected(err_unexpected), .err_timeout(err_timeout)
    );

    typedef struct {
        logic        rv;
        logic [15:0] ra;
        logic        ack;
        logic [15:0] rta;
        logic [15:0] rtd;
        logic        e_rd_en;
        logic [15:0] e_rda;
        logic        e_rv;
        logic [15:0] e_ra;
        logic [15:0] e_rd;
        logic [2:0]  e_out;
        logic        e_rdy;
        logic        e_eu;
    } vec_t;

    vec_t vt [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_address    = '0;
        rd_ret_ack     = 1'b0;
        rd_ret_address = '0;
        rd_ret_data    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_rd_en", 32'(rd_en), 32'h0);
        chk("rst_rd_address", 32'(rd_address), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_address", 32'(resp_address), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_outstanding", 32'(outstanding), 32'h0);
        chk("rst_err_unexpected", 32'(err_unexpected), 32'h0);
        chk("rst_err_timeout", 32'(err_timeout), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
    endtask

    initial begin
        int pulses;
        logic [15:0] pending[$];
        logic [15:0] issued[$];

        // rv  ra       ack rta      rtd       rd_en rda      rv  ra       rd       out   rdy eu
        vt[0]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0010, 1'b1, 16'h0010, 16'hBEEF, 3'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0010, 16'hBEEF, 3'd0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 16'h7777, 16'h1234, 1'b0, 16'h0010, 1'b0, 16'h0010, 16'hBEEF, 3'd0, 1'b1, 1'b1};
        vt[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0010, 16'hBEEF, 3'd0, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0010, 16'hBEEF, 3'd0, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h0010, 16'hBEEF, 3'd1, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0020, 1'b0, 16'h0010, 16'hBEEF, 3'd1, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0020, 1'b0, 16'h0010, 16'hBEEF, 3'd1, 1'b1, 1'b1};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 16'h0020, 16'h5555, 1'b0, 16'h0020, 1'b1, 16'h0020, 16'h5555, 3'd0, 1'b1, 1'b1};
        vt[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h0020, 16'h5555, 3'd1, 1'b1, 1'b1};
        vt[12] = '{1'b0, 16'h0000, 1'b1, 16'h0020, 16'h6666, 1'b0, 16'h0020, 1'b1, 16'h0020, 16'h6666, 3'd0, 1'b1, 1'b1};
        vt[13] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0020, 1'b0, 16'h0020, 16'h6666, 3'd0, 1'b1, 1'b1};

        do_reset();

        // Single issue/return, unexpected return, duplicate-tag stall
        for (int i = 0; i < 14; i++) begin
            req_valid      = vt[i].rv;
            req_address    = vt[i].ra;
            rd_ret_ack     = vt[i].ack;
            rd_ret_address = vt[i].rta;
            rd_ret_data    = vt[i].rtd;
            step();
            chk($sformatf("v%0d_rd_en", i), 32'(rd_en), 32'(vt[i].e_rd_en));
            chk($sformatf("v%0d_rd_address", i), 32'(rd_address), 32'(vt[i].e_rda));
            chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d_resp_address", i), 32'(resp_address), 32'(vt[i].e_ra));
            chk($sformatf("v%0d_resp_data", i), 32'(resp_data), 32'(vt[i].e_rd));
            chk($sformatf("v%0d_outstanding", i), 32'(outstanding), 32'(vt[i].e_out));
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_err_unexpected", i), 32'(err_unexpected), 32'(vt[i].e_eu));
        end
        idle_inputs();

        // Six pushes, no returns: table caps at four in flight
        do_reset();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid   = 1'b1;
            req_address = 16'h0100 + 16'(i);
            step();
            if (rd_en) pulses++;
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            step();
            if (rd_en) pulses++;
        end
        chk("t2_pulses", 32'(pulses), 32'd4);
        chk("t2_outstanding", 32'(outstanding), 32'd4);
        rd_ret_ack     = 1'b1;
        rd_ret_address = 16'h0101;
        rd_ret_data    = 16'hA101;
        step();
        idle_inputs();
        chk("t2_ret_resp_valid", 32'(resp_valid), 32'h1);
        chk("t2_ret_resp_address", 32'(resp_address), 32'h0101);
        chk("t2_ret_resp_data", 32'(resp_data), 32'hA101);
        chk("t2_ret_rd_en", 32'(rd_en), 32'h0);
        chk("t2_ret_outstanding", 32'(outstanding), 32'd3);
        step();
        chk("t2_next_rd_en", 32'(rd_en), 32'h1);
        chk("t2_next_rd_address", 32'(rd_address), 32'h0104);
        chk("t2_next_outstanding", 32'(outstanding), 32'd4);

        // Full table, then fill FIFO to DEPTH; extra request must be refused
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_valid   = 1'b1;
            req_address = 16'h0200 + 16'(i);
            step();
        end
        idle_inputs();
        repeat (3) step();
        chk("t4_table_full", 32'(outstanding), 32'd4);
        for (int i = 0; i < 8; i++) begin
            req_valid   = 1'b1;
            req_address = 16'h0300 + 16'(i);
            step();
            chk($sformatf("t4_ready_after_%0d", i + 1), 32'(req_ready), (i < 7) ? 32'h1 : 32'h0);
        end
        req_address = 16'h03FF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t4_ready_held_%0d", i), 32'(req_ready), 32'h0);
        end
        idle_inputs();
        pending = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
        for (int c = 0; c < 40; c++) begin
            if (pending.size() > 0) begin
                rd_ret_ack     = 1'b1;
                rd_ret_address = pending.pop_front();
            end else begin
                rd_ret_ack = 1'b0;
            end
            step();
            if (rd_en) begin
                issued.push_back(rd_address);
                pending.push_back(rd_address);
            end
        end
        idle_inputs();
        chk("t4_issued_count", 32'(issued.size()), 32'd8);
        for (int i = 0; i < 8 && i < issued.size(); i++) begin
            chk($sformatf("t4_issue_order_%0d", i), 32'(issued[i]), 32'h0300 + 32'(i));
        end
        chk("t4_drained", 32'(outstanding), 32'd0);
        chk("t4_no_unexpected", 32'(err_unexpected), 32'h0);
        chk("t4_ready_reopened", 32'(req_ready), 32'h1);

        // Aging entry with no return
        do_reset();
        req_valid   = 1'b1;
        req_address = 16'h0030;
        step();
        idle_inputs();
        step();
        chk("t6_issue", 32'(rd_en), 32'h1);
        repeat (63) step();
        chk("t6_err_timeout_early", 32'(err_timeout), 32'h0);
        repeat (3) step();
`ifdef MEM_RD_TIMEOUT_EN
        chk("t6_err_timeout_set", 32'(err_timeout), 32'h1);
`else
        chk("t6_err_timeout_tied", 32'(err_timeout), 32'h0);
`endif
        repeat (14) step();
`ifdef MEM_RD_TIMEOUT_EN
        chk("t6_err_timeout_sticky", 32'(err_timeout), 32'h1);
`else
        chk("t6_err_timeout_still0", 32'(err_timeout), 32'h0);
`endif
        chk("t6_still_outstanding", 32'(outstanding), 32'd1);

        // Reset drops the in-flight entry; its late return is unexpected
        do_reset();
        rd_ret_ack     = 1'b1;
        rd_ret_address = 16'h0030;
        rd_ret_data    = 16'h3030;
        step();
        idle_inputs();
        chk("rst_late_err_unexpected", 32'(err_unexpected), 32'h1);
        chk("rst_late_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_late_outstanding", 32'(outstanding), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
